fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of a fifo_1x1 between NUM_REQ requesters on one clock domain. Accepts at most one word per cycle and forwards it combinationally to the FIFO write port. Lets the current owner hold the port for a bounded burst, then rotates fairly. It never writes while the FIFO reports full.

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters,
// with bounded-burst ownership and a hard stall while the FIFO is full.
//
// state  | meaning
// IDLE   | no owner; the next word goes to the rr_ptr-ordered winner
// LOCKED | owner holds the port until burst end, req_last or owner drop
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          owner_valid,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_nxt;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    next_id = (int'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    rr_nxt    = rr_ptr;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    if (!reset && !fifo_full) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt_any   = 1'b1;
            gnt_id    = win_id;
            burst_nxt = CNT_W'(1);
            if (req_last[win_id] || BURST_LEN == 1) begin
              rr_nxt = next_id(win_id);
            end else begin
              state_nxt = LOCKED;
              owner_nxt = win_id;
            end
          end
        end
        LOCKED: begin
          if (req[owner]) begin
            gnt_any   = 1'b1;
            gnt_id    = owner;
            burst_nxt = burst_cnt + CNT_W'(1);
            if (burst_cnt + CNT_W'(1) == CNT_W'(BURST_LEN) || req_last[owner]) begin
              state_nxt = IDLE;
              rr_nxt    = next_id(owner);
            end
          end else begin
            // Owner dropped its request: release with a one-cycle bubble.
            state_nxt = IDLE;
            rr_nxt    = next_id(owner);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  always_comb begin
    grant        = '0;
    fifo_wr_data = '0;
    if (gnt_any) begin
      grant[gnt_id] = 1'b1;
      fifo_wr_data  = req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en  = gnt_any;
  assign owner_valid = !reset && (state == LOCKED);
  assign owner_id    = owner_valid ? owner : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed cycles push hand-computed
// expectations, a negedge monitor pops and compares the DUT outputs.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req_data = '0;
  logic [3:0] req_last = '0;
  logic [3:0] grant;
  logic       fifo_wr_en;
  logic [0:0] fifo_wr_data;
  logic       fifo_full = 1'b0;
  logic       owner_valid;
  logic [1:0] owner_id;

  typedef struct {
    logic [3:0] g;
    logic       d;
    logic       ov;
    logic [1:0] oid;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(1), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .grant(grant),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full),
    .owner_valid(owner_valid),
    .owner_id(owner_id)
  );

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (grant !== e.g || fifo_wr_en !== (|e.g) || fifo_wr_data !== e.d ||
          owner_valid !== e.ov || owner_id !== e.oid) begin
        bad++;
        $display("FAIL chk%0d: got grant=%b wr_en=%b data=%b ov=%b oid=%0d, want grant=%b wr_en=%b data=%b ov=%b oid=%0d",
                 e.id, grant, fifo_wr_en, fifo_wr_data, owner_valid, owner_id,
                 e.g, |e.g, e.d, e.ov, e.oid);
      end
    end
  end

  task automatic cyc(input logic rs, input logic [3:0] r, input logic [3:0] lst,
                     input logic fl, input logic [3:0] dat, input logic [3:0] eg,
                     input logic ed, input logic eov, input logic [1:0] eoid,
                     input int id);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rs;
    req      = r;
    req_last = lst;
    fifo_full = fl;
    req_data = dat;
    e.g = eg; e.d = ed; e.ov = eov; e.oid = eoid; e.id = id;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset with all requesting, then rotation with wrap (slice i = i%2).
    cyc(1, 4'b1111, 4'b0000, 0, 4'b1010, 4'b0000, 0, 0, 0, 100);
    cyc(1, 4'b1111, 4'b0000, 0, 4'b1010, 4'b0000, 0, 0, 0, 101);
    for (int b = 0; b < 4; b++) begin
      logic [3:0] g;
      g = 4'b0001 << b;
      for (int k = 0; k < 4; k++)
        cyc(0, 4'b1111, 4'b0000, 0, 4'b1010, g, logic'(b % 2), (k != 0),
            (k != 0) ? 2'(b) : 2'd0, 200 + b*10 + k);
    end
    cyc(0, 4'b1111, 4'b0000, 0, 4'b1010, 4'b0001, 0, 0, 0, 240);

    // Early end via req_last on the 2nd word.
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 0, 0, 0, 300);
    cyc(0, 4'b0101, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0, 0, 301);
    cyc(0, 4'b0101, 4'b0001, 0, 4'b0001, 4'b0001, 1, 1, 0, 302);
    cyc(0, 4'b0101, 4'b0000, 0, 4'b0001, 4'b0100, 0, 0, 0, 303);

    // Full stall while owner 1 is locked; non-owner 2 waits.
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 0, 0, 0, 400);
    cyc(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 0, 0, 401);
    cyc(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 1, 402);
    cyc(0, 4'b0110, 4'b0000, 1, 4'b0010, 4'b0000, 0, 1, 1, 403);
    cyc(0, 4'b0110, 4'b0000, 1, 4'b0010, 4'b0000, 0, 1, 1, 404);
    cyc(0, 4'b0110, 4'b0000, 1, 4'b0010, 4'b0000, 0, 1, 1, 405);
    cyc(0, 4'b0110, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 1, 406);
    cyc(0, 4'b0110, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 1, 407);
    cyc(0, 4'b0110, 4'b0000, 0, 4'b0010, 4'b0100, 0, 0, 0, 408);

    // Full in IDLE, then owner drop bubble.
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0000, 0, 0, 0, 500);
    cyc(0, 4'b0010, 4'b0000, 1, 4'b0100, 4'b0000, 0, 0, 0, 501);
    cyc(0, 4'b0010, 4'b0000, 0, 4'b0100, 4'b0010, 0, 0, 0, 502);
    cyc(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 0, 1, 1, 503);
    cyc(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 0, 0, 504);

    // Reset on owner 2's 3rd word; restart from index 0 pointer.
    cyc(0, 4'b0110, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, 2, 600);
    cyc(1, 4'b0110, 4'b0000, 0, 4'b0100, 4'b0000, 0, 0, 0, 601);
    cyc(0, 4'b0110, 4'b0000, 0, 4'b0100, 4'b0010, 0, 0, 0, 602);

    @(posedge clk);
    #1;
    req = '0;
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
